// File: rtl/core_cache_arbiter_if.sv
// core_cache_arbiter_if: request/completion bus between the arbiter and the cache
interface core_cache_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              valid;
    logic [1:0]        rw;
    logic [ADDR_W-1:0] address_cache;
    logic [DATA_W-1:0] cache_wdata;
    logic              cache_drive;
    logic [DATA_W-1:0] cache_rdata;
    logic              hit;
    logic              gnt;
    modport master (
        output valid, rw, address_cache, cache_wdata, cache_drive,
        input  cache_rdata, hit, gnt
    );
    modport slave (
        input  valid, rw, address_cache, cache_wdata, cache_drive,
        output cache_rdata, hit, gnt
    );
endinterface

// File: rtl/core_cache_arbiter.sv
// core_cache_arbiter: round-robin two-core arbiter for one cache port, with timeout and illegal-op abort
module core_cache_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    input  logic [1:0]         req_rw0,
    input  logic [1:0]         req_rw1,
    input  logic [ADDR_W-1:0]  req_addr0,
    input  logic [ADDR_W-1:0]  req_addr1,
    input  logic [DATA_W-1:0]  req_wdata0,
    input  logic [DATA_W-1:0]  req_wdata1,
    output logic [1:0]         req_gnt,
    output logic [1:0]         rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_hit,
    output logic               rsp_err,
    core_cache_arbiter_if.master cache
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t            state, state_n;
    logic              owner, owner_n, last_owner, last_n;
    logic [1:0]        lrw, lrw_n;
    logic [ADDR_W-1:0] laddr, laddr_n;
    logic [DATA_W-1:0] lwdata, lwdata_n, lrdata, lrdata_n;
    logic              lhit, lhit_n, lerr, lerr_n;
    logic [7:0]        cnt, cnt_n;
    logic              win;
    logic [1:0]        win_rw;
    assign win    = (req_valid == 2'b11) ? ~last_owner : req_valid[1];
    assign win_rw = win ? req_rw1 : req_rw0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lrw        <= '0;
            laddr      <= '0;
            lwdata     <= '0;
            lrdata     <= '0;
            lhit       <= 1'b0;
            lerr       <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_n;
            lrw        <= lrw_n;
            laddr      <= laddr_n;
            lwdata     <= lwdata_n;
            lrdata     <= lrdata_n;
            lhit       <= lhit_n;
            lerr       <= lerr_n;
            cnt        <= cnt_n;
        end
    end
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        last_n   = last_owner;
        lrw_n    = lrw;
        laddr_n  = laddr;
        lwdata_n = lwdata;
        lrdata_n = lrdata;
        lhit_n   = lhit;
        lerr_n   = lerr;
        cnt_n    = cnt;
        req_gnt  = 2'b00;
        case (state)
            IDLE: if (|req_valid) begin
                req_gnt  = win ? 2'b10 : 2'b01;
                owner_n  = win;
                last_n   = win;
                lrw_n    = win_rw;
                laddr_n  = win ? req_addr1 : req_addr0;
                lwdata_n = win ? req_wdata1 : req_wdata0;
                lrdata_n = '0;
                lhit_n   = 1'b0;
                lerr_n   = ~(win_rw == 2'b01 || win_rw == 2'b10);
                cnt_n    = '0;
                state_n  = lerr_n ? RESP : BUSY;
            end
            BUSY: begin
                cnt_n = cnt + 8'd1;
                if (cache.gnt) begin
                    lrdata_n = (lrw == 2'b10) ? '0 : cache.cache_rdata;
                    lhit_n   = cache.hit;
                    lerr_n   = 1'b0;
                    state_n  = RESP;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    lrdata_n = '0;
                    lhit_n   = 1'b0;
                    lerr_n   = 1'b1;
                    state_n  = RESP;
                end
            end
            RESP: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // Cache-side outputs are gated by state so they read as zero outside BUSY.
    assign cache.valid         = state == BUSY;
    assign cache.rw            = cache.valid ? lrw : 2'b00;
    assign cache.address_cache = cache.valid ? laddr : '0;
    assign cache.cache_wdata   = cache.valid ? lwdata : '0;
    assign cache.cache_drive   = cache.valid && lrw == 2'b10;
    assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = (state == RESP) ? lrdata : '0;
    assign rsp_hit   = state == RESP && lhit;
    assign rsp_err   = state == RESP && lerr;
endmodule

// File: tb/tb_core_cache_arbiter.sv
// tb_core_cache_arbiter: directed and randomized checks of the two-core cache arbiter
module tb_core_cache_arbiter;
    localparam int TO = 16;
    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  req_valid = '0, req_rw0 = '0, req_rw1 = '0;
    logic [11:0] req_addr0 = '0, req_addr1 = '0;
    logic [7:0]  req_wdata0 = '0, req_wdata1 = '0;
    logic [1:0]  req_gnt, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_hit, rsp_err;
    int          checks = 0, errors = 0;
    bit          m_last;
    core_cache_arbiter_if #(.ADDR_W(12), .DATA_W(8)) cif ();
    core_cache_arbiter #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_rw0(req_rw0), .req_rw1(req_rw1),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_hit(rsp_hit), .rsp_err(rsp_err), .cache(cif)
    );
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        cif.gnt = 1'b0; cif.hit = 1'b0; cif.cache_rdata = '0;
        rst = 1'b1;
        tick; tick;
        checks++;
        if ({req_gnt, rsp_valid, rsp_rdata, rsp_hit, rsp_err, cif.valid, cif.rw, cif.address_cache, cif.cache_wdata, cif.cache_drive} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {req_gnt, rsp_valid, rsp_rdata, rsp_hit, rsp_err, cif.valid, cif.rw, cif.address_cache, cif.cache_wdata, cif.cache_drive});
        end
        rst = 1'b0;
        m_last = 1'b1;
        tick;
    endtask
    task automatic test_read;
        req_valid = 2'b01; req_rw0 = 2'b01; req_addr0 = 12'h0A5; req_wdata0 = 8'hEE;
        #1;
        checks++;
        if (req_gnt !== 2'b01) begin errors++; $display("FAIL read_gnt got %b exp 01", req_gnt); end
        tick;
        req_valid = 2'b00;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++;
            if ({cif.valid, cif.rw, cif.address_cache, cif.cache_drive, rsp_valid} !== {1'b1, 2'b01, 12'h0A5, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL read_busy c%0d got %h exp %h", c, {cif.valid, cif.rw, cif.address_cache, cif.cache_drive, rsp_valid}, {1'b1, 2'b01, 12'h0A5, 1'b0, 2'b00});
            end
            if (c == 3) begin cif.gnt = 1'b1; cif.hit = 1'b1; cif.cache_rdata = 8'h3C; end
            tick;
            cif.gnt = 1'b0; cif.hit = 1'b0; cif.cache_rdata = '0;
        end
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err, cif.valid} !== {2'b01, 8'h3C, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_rsp got %h exp %h", {rsp_valid, rsp_rdata, rsp_hit, rsp_err, cif.valid}, {2'b01, 8'h3C, 1'b1, 1'b0, 1'b0});
        end
        tick;
        m_last = 1'b0;
    endtask
    task automatic test_write;
        req_valid = 2'b10; req_rw1 = 2'b10; req_addr1 = 12'hFFF; req_wdata1 = 8'h5A;
        #1;
        checks++;
        if (req_gnt !== 2'b10) begin errors++; $display("FAIL write_gnt got %b exp 10", req_gnt); end
        tick;
        req_valid = 2'b00;
        #1;
        checks++;
        if ({cif.valid, cif.rw, cif.address_cache, cif.cache_wdata, cif.cache_drive} !== {1'b1, 2'b10, 12'hFFF, 8'h5A, 1'b1}) begin
            errors++;
            $display("FAIL write_busy got %h exp %h", {cif.valid, cif.rw, cif.address_cache, cif.cache_wdata, cif.cache_drive}, {1'b1, 2'b10, 12'hFFF, 8'h5A, 1'b1});
        end
        cif.gnt = 1'b1; cif.hit = 1'b0; cif.cache_rdata = 8'h77;
        tick;
        cif.gnt = 1'b0; cif.cache_rdata = '0;
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err, cif.cache_drive} !== {2'b10, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL write_rsp got %h exp %h", {rsp_valid, rsp_rdata, rsp_hit, rsp_err, cif.cache_drive}, {2'b10, 8'h00, 1'b0, 1'b0, 1'b0});
        end
        tick;
        m_last = 1'b1;
    endtask
    task automatic test_fairness;
        logic [1:0] exp_gnt;
        req_valid = 2'b11; req_rw0 = 2'b01; req_rw1 = 2'b01;
        for (int t = 0; t < 4; t++) begin
            exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if ({req_gnt, cif.valid} !== {exp_gnt, 1'b0}) begin
                errors++;
                $display("FAIL fair_gnt t%0d got %b exp %b", t, {req_gnt, cif.valid}, {exp_gnt, 1'b0});
            end
            tick;
            checks++;
            if ({req_gnt, cif.valid} !== 3'b001) begin
                errors++;
                $display("FAIL fair_busy t%0d got %b exp 001", t, {req_gnt, cif.valid});
            end
            cif.gnt = 1'b1; cif.cache_rdata = 8'(8'h10 + t);
            tick;
            cif.gnt = 1'b0;
            checks++;
            if ({req_gnt, cif.valid, rsp_valid, rsp_rdata} !== {2'b00, 1'b0, exp_gnt, 8'(8'h10 + t)}) begin
                errors++;
                $display("FAIL fair_rsp t%0d got %h exp %h", t, {req_gnt, cif.valid, rsp_valid, rsp_rdata}, {2'b00, 1'b0, exp_gnt, 8'(8'h10 + t)});
            end
            tick;
        end
        req_valid = 2'b00;
        m_last = 1'b1;
    endtask
    task automatic test_timeout;
        int high;
        req_valid = 2'b01; req_rw0 = 2'b01; req_addr0 = 12'h123;
        tick;
        req_valid = 2'b00;
        cif.hit = 1'b1; cif.cache_rdata = 8'hAB;
        high = 0;
        for (int c = 0; c < TO + 2 && cif.valid; c++) begin
            high++;
            tick;
        end
        checks++;
        if (high !== TO) begin errors++; $display("FAIL timeout_len got %0d exp %0d", high, TO); end
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err, cif.valid} !== {2'b01, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_rsp got %h exp %h", {rsp_valid, rsp_rdata, rsp_hit, rsp_err, cif.valid}, {2'b01, 8'h00, 1'b0, 1'b1, 1'b0});
        end
        tick;
        cif.hit = 1'b0; cif.cache_rdata = '0;
        checks++;
        if ({rsp_valid, cif.valid} !== 3'b000) begin errors++; $display("FAIL timeout_idle got %b exp 000", {rsp_valid, cif.valid}); end
        m_last = 1'b0;
    endtask
    task automatic test_illegal;
        req_valid = 2'b01; req_rw0 = 2'b11;
        #1;
        checks++;
        if (req_gnt !== 2'b01) begin errors++; $display("FAIL illegal_gnt got %b exp 01", req_gnt); end
        tick;
        req_valid = 2'b00;
        checks++;
        if ({cif.valid, cif.rw, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 2'b00, 2'b01, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL illegal_rsp got %h exp %h", {cif.valid, cif.rw, rsp_valid, rsp_err, rsp_rdata}, {1'b0, 2'b00, 2'b01, 1'b1, 8'h00});
        end
        cif.gnt = 1'b1;
        tick;
        cif.gnt = 1'b0;
        checks++;
        if ({rsp_valid, cif.valid} !== 3'b000) begin errors++; $display("FAIL resp_gnt_ignored got %b exp 000", {rsp_valid, cif.valid}); end
        m_last = 1'b0;
        req_rw0 = 2'b01;
    endtask
    task automatic test_reset_busy;
        req_valid = 2'b10; req_rw1 = 2'b10; req_addr1 = 12'h456; req_wdata1 = 8'h99;
        tick;
        req_valid = 2'b00;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({req_gnt, rsp_valid, rsp_rdata, rsp_hit, rsp_err, cif.valid, cif.rw, cif.address_cache, cif.cache_wdata, cif.cache_drive} !== 38'd0) begin
            errors++;
            $display("FAIL rstbusy_outputs got %h exp 0", {req_gnt, rsp_valid, rsp_rdata, rsp_hit, rsp_err, cif.valid, cif.rw, cif.address_cache, cif.cache_wdata, cif.cache_drive});
        end
        m_last = 1'b1;
        cif.gnt = 1'b1; cif.hit = 1'b1;
        tick;
        cif.gnt = 1'b0; cif.hit = 1'b0;
        checks++;
        if ({rsp_valid, cif.valid} !== 3'b000) begin errors++; $display("FAIL rstbusy_stray got %b exp 000", {rsp_valid, cif.valid}); end
        req_valid = 2'b11; req_rw0 = 2'b01; req_rw1 = 2'b01;
        #1;
        checks++;
        if (req_gnt !== 2'b01) begin errors++; $display("FAIL rstbusy_tie got %b exp 01", req_gnt); end
        tick;
        req_valid = 2'b00;
        cif.gnt = 1'b1;
        tick;
        cif.gnt = 1'b0;
        tick;
        m_last = 1'b0;
    endtask
    task automatic test_random;
        logic [1:0]  rv, egnt, rws;
        logic [11:0] a;
        logic [7:0]  d, r, erd;
        logic        eh, ee, ok;
        bit          win;
        int          delay;
        rv = 2'b00;
        for (int t = 0; t < 80; t++) begin
            rv = rv | 2'($urandom_range(0, 3));
            req_valid = rv;
            req_rw0 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1) * 3) : 2'($urandom_range(1, 2));
            req_rw1 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1) * 3) : 2'($urandom_range(1, 2));
            req_addr0 = 12'($urandom); req_addr1 = 12'($urandom);
            req_wdata0 = 8'($urandom); req_wdata1 = 8'($urandom);
            #1;
            if (rv == 2'b00) begin
                checks++;
                if ({req_gnt, cif.valid} !== 3'b000) begin errors++; $display("FAIL rnd_idle t%0d got %b exp 000", t, {req_gnt, cif.valid}); end
                tick;
                continue;
            end
            win  = (rv == 2'b11) ? !m_last : rv[1];
            egnt = win ? 2'b10 : 2'b01;
            checks++;
            if (req_gnt !== egnt) begin errors++; $display("FAIL rnd_gnt t%0d got %b exp %b", t, req_gnt, egnt); end
            m_last = win;
            rws = win ? req_rw1 : req_rw0;
            a   = win ? req_addr1 : req_addr0;
            d   = win ? req_wdata1 : req_wdata0;
            ok  = rws == 2'b01 || rws == 2'b10;
            delay = $urandom_range(1, TO + 4);
            erd = '0; eh = 1'b0; ee = !ok;
            tick;
            rv[win] = 1'b0;
            req_valid = rv;
            #1;
            if (ok) begin
                for (int c = 1; c <= TO; c++) begin
                    checks++;
                    if ({req_gnt, cif.valid, cif.rw, cif.address_cache, cif.cache_wdata, cif.cache_drive} !== {2'b00, 1'b1, rws, a, d, rws == 2'b10}) begin
                        errors++;
                        $display("FAIL rnd_busy t%0d c%0d got %h exp %h", t, c, {req_gnt, cif.valid, cif.rw, cif.address_cache, cif.cache_wdata, cif.cache_drive}, {2'b00, 1'b1, rws, a, d, rws == 2'b10});
                    end
                    r = 8'($urandom);
                    cif.cache_rdata = r;
                    cif.hit = 1'($urandom);
                    if (c == delay) begin
                        cif.gnt = 1'b1;
                        eh  = cif.hit;
                        erd = (rws == 2'b10) ? 8'h00 : r;
                    end
                    tick;
                    cif.gnt = 1'b0;
                    if (c == delay) break;
                end
                if (delay > TO) ee = 1'b1;
            end
            checks++;
            if ({req_gnt, cif.valid, rsp_valid, rsp_rdata, rsp_hit, rsp_err} !== {2'b00, 1'b0, egnt, erd, eh, ee}) begin
                errors++;
                $display("FAIL rnd_rsp t%0d got %h exp %h", t, {req_gnt, cif.valid, rsp_valid, rsp_rdata, rsp_hit, rsp_err}, {2'b00, 1'b0, egnt, erd, eh, ee});
            end
            cif.gnt = 1'($urandom);
            tick;
            cif.gnt = 1'b0;
        end
        req_valid = 2'b00;
        tick;
    endtask
    initial begin
        test_reset;
        test_read;
        test_write;
        test_fairness;
        test_timeout;
        test_illegal;
        test_reset_busy;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
